// File: rtl/fetch_queue_pkg.sv
// Shared constants and small helpers for the fetch-to-decode queue.
// Bus width and excp bit index mirror the CPU-wide fetch/decode bus layout.
package fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD  = 109;
    localparam int FQ_DEPTH_DEFAULT = 4;
    localparam int FQ_EXCP_BIT      = 68;

    typedef enum logic [1:0] {
        FQ_HOLD = 2'b00,
        FQ_POP  = 2'b01,
        FQ_PUSH = 2'b10,
        FQ_BOTH = 2'b11
    } fq_op_e;

    function automatic fq_op_e fq_op(input logic push, input logic pop);
        return fq_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch stage, queue and decode stage.
// The queue side uses the slave modport; the master modport is the surrounding pipeline.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEFAULT,
    parameter int FQ_WD    = FS_TO_DS_BUS_WD
);
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic             flush;
    logic             fs_to_ds_valid;
    logic [FQ_WD-1:0] fs_to_ds_bus;
    logic             fq_allowin;
    logic             fq_to_ds_valid;
    logic [FQ_WD-1:0] fq_to_ds_bus;
    logic             ds_allowin;
    logic [CNT_W-1:0] fq_count;

    modport master (
        output flush, fs_to_ds_valid, fs_to_ds_bus, ds_allowin,
        input  fq_allowin, fq_to_ds_valid, fq_to_ds_bus, fq_count
    );

    modport slave (
        input  flush, fs_to_ds_valid, fs_to_ds_bus, ds_allowin,
        output fq_allowin, fq_to_ds_valid, fq_to_ds_bus, fq_count
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO decoupling fetch from decode; an excepting entry locks further
// pushes until the pipeline is flushed.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEFAULT,
    parameter int FQ_WD    = FS_TO_DS_BUS_WD
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FQ_WD-1:0] storage_r [FQ_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             excp_lock_r;

    logic             allowin_s;
    logic             valid_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_next_s;

    // allowin depends only on registered state so decode backpressure never reaches fetch combinationally
    always_comb begin
        allowin_s    = (count_r < CNT_W'(FQ_DEPTH)) && !excp_lock_r;
        valid_s      = (count_r != CNT_W'(0)) && !fq.flush;
        push_s       = fq.fs_to_ds_valid && allowin_s && !fq.flush;
        pop_s        = valid_s && fq.ds_allowin;
        count_next_s = count_r;
        case (fq_op(push_s, pop_s))
            FQ_PUSH: count_next_s = count_r + CNT_W'(1);
            FQ_POP:  count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and lock state; reset outranks flush, flush outranks traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r      <= PTR_W'(0);
            tail_r      <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            excp_lock_r <= 1'b0;
        end else if (fq.flush) begin
            head_r      <= PTR_W'(0);
            tail_r      <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            excp_lock_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            if (push_s && fq.fs_to_ds_bus[FQ_EXCP_BIT]) begin
                excp_lock_r <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: the head is only meaningful while valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            storage_r[tail_r] <= fq.fs_to_ds_bus;
        end
    end

    assign fq.fq_allowin     = allowin_s;
    assign fq.fq_to_ds_valid = valid_s;
    assign fq.fq_to_ds_bus   = storage_r[head_r];
    assign fq.fq_count       = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int WD    = 109;
    localparam int EXCP  = 68;
    localparam logic [31:0] PC0 = 32'h1c00_0000;

    logic clk;
    logic reset;

    fetch_queue_if #(.FQ_DEPTH(DEPTH), .FQ_WD(WD)) fq_bus ();

    fetch_queue #(.FQ_DEPTH(DEPTH), .FQ_WD(WD)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WD-1:0] mq [$];
    bit            mlock;

    bit            cur_v;
    logic [WD-1:0] cur_bus;
    bit            cur_ds;
    bit            cur_fl;
    bit            cur_rs;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          ds;
        bit          exp_valid;
        bit          exp_allow;
        int          exp_count;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [WD-1:0] mk_bus(input logic [31:0] pc, input bit excp);
        logic [WD-1:0] b;
        b = '0;
        b[31:0] = pc;
        b[WD-1:WD-32] = ~pc;
        b[EXCP] = excp;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [WD-1:0] b, input bit ds, input bit fl, input bit rs);
        @(negedge clk);
        cur_v = v; cur_bus = b; cur_ds = ds; cur_fl = fl; cur_rs = rs;
        fq_bus.fs_to_ds_valid = v;
        fq_bus.fs_to_ds_bus   = b;
        fq_bus.ds_allowin     = ds;
        fq_bus.flush          = fl;
        reset                 = rs;
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ev;
        bit ea;
        ev = (mq.size() != 0) && !cur_fl;
        ea = (mq.size() < DEPTH) && !mlock;
        chk({tag, "_count"}, 128'(fq_bus.fq_count), 128'(mq.size()));
        chk({tag, "_allowin"}, 128'(fq_bus.fq_allowin), 128'(ea));
        chk({tag, "_valid"}, 128'(fq_bus.fq_to_ds_valid), 128'(ev));
        if (ev) chk({tag, "_bus"}, 128'(fq_bus.fq_to_ds_bus), 128'(mq[0]));
    endtask

    // Apply the queue rules to the model, then let the edge happen
    task automatic advance();
        bit ev;
        bit ea;
        ev = (mq.size() != 0) && !cur_fl;
        ea = (mq.size() < DEPTH) && !mlock;
        if (cur_rs || cur_fl) begin
            mq.delete();
            mlock = 1'b0;
        end else begin
            if (ev && cur_ds) void'(mq.pop_front());
            if (cur_v && ea) begin
                mq.push_back(cur_bus);
                if (cur_bus[EXCP]) mlock = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_check(input string tag);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_model(tag);
        advance();
    endtask

    initial begin
        logic [31:0] got [$];
        fq_bus.fs_to_ds_valid = 1'b0;
        fq_bus.fs_to_ds_bus   = '0;
        fq_bus.ds_allowin     = 1'b0;
        fq_bus.flush          = 1'b0;
        reset                 = 1'b1;
        mlock                 = 1'b0;

        // Reset: outputs before the first reset are unknown, so only check after it
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 128'(fq_bus.fq_count), 128'(0));
        chk("reset_valid", 128'(fq_bus.fq_to_ds_valid), 128'(0));
        chk("reset_allowin", 128'(fq_bus.fq_allowin), 128'(1));
        advance();

        // Fill, full-push rejection, streaming drain
        vecs[0]  = '{1'b1, PC0 + 32'h00, 1'b0, 1'b0, 1'b1, 0, 32'h0};
        vecs[1]  = '{1'b1, PC0 + 32'h04, 1'b0, 1'b1, 1'b1, 1, PC0 + 32'h00};
        vecs[2]  = '{1'b1, PC0 + 32'h08, 1'b0, 1'b1, 1'b1, 2, PC0 + 32'h00};
        vecs[3]  = '{1'b1, PC0 + 32'h0c, 1'b0, 1'b1, 1'b1, 3, PC0 + 32'h00};
        vecs[4]  = '{1'b1, PC0 + 32'h10, 1'b0, 1'b1, 1'b0, 4, PC0 + 32'h00};
        vecs[5]  = '{1'b1, PC0 + 32'h10, 1'b1, 1'b1, 1'b0, 4, PC0 + 32'h00};
        vecs[6]  = '{1'b1, PC0 + 32'h10, 1'b1, 1'b1, 1'b1, 3, PC0 + 32'h04};
        vecs[7]  = '{1'b1, PC0 + 32'h14, 1'b1, 1'b1, 1'b1, 3, PC0 + 32'h08};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 3, PC0 + 32'h0c};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2, PC0 + 32'h10};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1, PC0 + 32'h14};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, mk_bus(vecs[i].pc, 1'b0), vecs[i].ds, 1'b0, 1'b0);
            chk($sformatf("vec%0d_count", i), 128'(fq_bus.fq_count), 128'(vecs[i].exp_count));
            chk($sformatf("vec%0d_allowin", i), 128'(fq_bus.fq_allowin), 128'(vecs[i].exp_allow));
            chk($sformatf("vec%0d_valid", i), 128'(fq_bus.fq_to_ds_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_pc", i), 128'(fq_bus.fq_to_ds_bus[31:0]), 128'(vecs[i].exp_pc));
            advance();
        end

        // Wrap: ten push/pop pairs at depth 4
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, mk_bus(PC0 + 32'(4 * i), 1'b0), 1'b1, 1'b0, 1'b0);
            check_model("wrap");
            if (fq_bus.fq_to_ds_valid) got.push_back(fq_bus.fq_to_ds_bus[31:0]);
            advance();
        end
        chk("wrap_pops", 128'(got.size()), 128'(10));
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk($sformatf("wrap_order%0d", i), 128'(got[i]), 128'(PC0 + 32'(4 * i)));

        // Flush with three entries and concurrent push/pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk_bus(32'h2000_0000 + 32'(i), 1'b0), 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, mk_bus(32'hdead_0000, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("flush_valid_same_cycle", 128'(fq_bus.fq_to_ds_valid), 128'(0));
        advance();
        drive(1'b1, mk_bus(32'h3000_0000, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("flush_count", 128'(fq_bus.fq_count), 128'(0));
        chk("flush_valid", 128'(fq_bus.fq_to_ds_valid), 128'(0));
        chk("flush_allowin", 128'(fq_bus.fq_allowin), 128'(1));
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_next_head", 128'(fq_bus.fq_to_ds_bus[31:0]), 128'(32'h3000_0000));
        advance();

        // Exception lock at count 1
        drive(1'b1, mk_bus(32'h4000_0000, 1'b1), 1'b0, 1'b0, 1'b0); check_model("excp_push"); advance();
        drive(1'b1, mk_bus(32'h4000_0004, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("excp_allowin", 128'(fq_bus.fq_allowin), 128'(0));
        chk("excp_count", 128'(fq_bus.fq_count), 128'(2));
        advance();
        drive(1'b1, mk_bus(32'h4000_0008, 1'b0), 1'b1, 1'b0, 1'b0); check_model("excp_drain0"); advance();
        drive(1'b1, mk_bus(32'h4000_000c, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("excp_entry_pops", 128'(fq_bus.fq_to_ds_bus[EXCP]), 128'(1));
        check_model("excp_drain1");
        advance();
        drive(1'b1, mk_bus(32'h4000_0010, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("excp_still_locked", 128'(fq_bus.fq_allowin), 128'(0));
        chk("excp_empty", 128'(fq_bus.fq_count), 128'(0));
        advance();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("excp_unlock", 128'(fq_bus.fq_allowin), 128'(1));
        advance();

        // Reset at count 2 with a push pending
        drive(1'b1, mk_bus(32'h5000_0000, 1'b0), 1'b0, 1'b0, 1'b0); advance();
        drive(1'b1, mk_bus(32'h5000_0004, 1'b0), 1'b0, 1'b0, 1'b0); advance();
        drive(1'b1, mk_bus(32'h5000_0008, 1'b0), 1'b1, 1'b1, 1'b1);
        chk("rst_pre_count", 128'(fq_bus.fq_count), 128'(2));
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_count", 128'(fq_bus.fq_count), 128'(0));
        chk("rst_valid", 128'(fq_bus.fq_to_ds_valid), 128'(0));
        chk("rst_allowin", 128'(fq_bus.fq_allowin), 128'(1));
        advance();
        idle_check("post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  mk_bus($urandom(), $urandom_range(0, 15) == 0),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) == 0);
            check_model("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, number of entries; power of two, 2..16.
REQ-002 SHALL have parameter FQ_WD, default `FS_TO_DS_BUS_WD (109), entry width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  OR of excp/ertn/refetch/icacop/idle flush and btb_pre_error_flush.
REQ-006 SHALL have port fs_to_ds_valid  input  1  fetch-side entry valid.
REQ-007 SHALL have port fs_to_ds_bus  input  FQ_WD  fetch-side entry; bit 68 = excp flag, other fields opaque.
REQ-008 SHALL have port fq_allowin  output  1  queue accepts a push; drives fetch-stage ds_allowin.
REQ-009 SHALL have port fq_to_ds_valid  output  1  head entry valid toward decode.
REQ-010 SHALL have port fq_to_ds_bus  output  FQ_WD  head entry, bit-identical to the pushed value.
REQ-011 SHALL have port ds_allowin  input  1  decode accepts the head entry.
REQ-012 SHALL have port fq_count  output  $clog2(FQ_DEPTH)+1  current occupancy.

Function
REQ-013 SHALL be a circular buffer: head/tail pointers $clog2(FQ_DEPTH) bits wide, wrapping modulo FQ_DEPTH; count 0..FQ_DEPTH.
REQ-014 SHALL push when fs_to_ds_valid && fq_allowin && !flush: write entry at tail, tail+1.
REQ-015 SHALL pop when fq_to_ds_valid && ds_allowin: head+1.
REQ-016 SHALL compute fq_allowin = (count < FQ_DEPTH) && !excp_lock from registered state only; no combinational path from ds_allowin.
REQ-017 SHALL compute fq_to_ds_valid = (count != 0) && !flush; fq_to_ds_bus = storage[head] (register read, no bypass).
REQ-018 SHALL give push-to-visible latency of exactly 1 cycle: entry pushed at edge N is at the head after edge N+1 if the queue was empty.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL not push when full (fq_allowin=0) even if a pop occurs the same cycle.
REQ-021 SHALL set excp_lock when a pushed entry has bit 68 = 1; while locked, fq_allowin=0; the excepting entry still drains normally.
REQ-022 SHALL, on flush in cycle N, suppress push and pop in cycle N and present count=0, head=tail=0, excp_lock=0 after edge N; storage contents need not be cleared.
REQ-023 SHALL give flush priority over push, pop and excp_lock set in the same cycle.
REQ-024 SHALL preserve entry order strictly FIFO; no reordering, no dropping except on flush.

Reset
REQ-025 SHALL, with reset high at an edge, set count=0, head=0, tail=0, excp_lock=0; hence fq_to_ds_valid=0, fq_allowin=1, fq_count=0 after that edge.
REQ-026 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries.
REQ-027 SHALL not require storage array reset; fq_to_ds_bus is don't-care while fq_to_ds_valid=0.

Structure
REQ-028 SHALL take FS_TO_DS_BUS_WD and the default FQ_DEPTH from the shared header mycpu.h; the excp bit index (68) SHALL be a named macro there.
REQ-029 SHALL contain no sub-module; storage is an inline register array in this module.
REQ-030 SHALL be instantiated between if_stage and id_stage, with fq_allowin feeding if_stage ds_allowin and fq_to_ds_* replacing fs_to_ds_* toward id_stage.

Verification
REQ-031 Fill: 4 pushes of pc 0x1c000000..0x1c00000c, ds_allowin=0 -> fq_count=4, fq_allowin=0 next cycle, head pc 0x1c000000.
REQ-032 Drain with streaming: full queue, ds_allowin=1 and fs valid every cycle -> one pop per cycle, count drops 4->3 then stays 3 (push resumes after allowin rises), order preserved.
REQ-033 Wrap: 10 push/pop pairs at depth 4 -> pcs 0x1c000000..0x1c000024 emerge in order, pointers wrap twice.
REQ-034 Flush with 3 entries and concurrent push/pop -> next cycle count=0, fq_to_ds_valid=0, fq_allowin=1; flush-cycle pushed entry never appears.
REQ-035 Exception lock: push entry with bit 68=1 at count=1 -> fq_allowin=0 next cycle until flush, excepting entry still popped.
REQ-036 Reset asserted at count=2 with push pending -> next cycle count=0, fq_to_ds_valid=0, fq_allowin=1.
